// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: transfer size codes,
// access direction, FSM state encoding and an alignment helper.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_ERR = 2'b00;
    localparam logic [1:0] SZ_B   = 2'b01;
    localparam logic [1:0] SZ_H   = 2'b10;
    localparam logic [1:0] SZ_W   = 2'b11;

    localparam logic DRW_READ = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // True when a halfword/word transfer does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Little-endian byte-lane mapper: turns size/offset into SRAM byte enables,
// replicates store data across lanes and extracts zero-extended load data.
// Misaligned offsets are aligned down (halfword uses off[1], word ignores off).
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext
);

    logic [31:0] rd_byte_sh;
    logic [15:0] rd_half;

    assign rd_byte_sh = rdata >> {off, 3'b000};
    assign rd_half    = off[1] ? rdata[31:16] : rdata[15:0];

    // Lane selection per transfer size; illegal size enables nothing.
    always_comb begin
        be        = 4'b0000;
        wdata     = 32'h0;
        rdata_ext = 32'h0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << off;
                wdata     = {4{wdata_in[7:0]}};
                rdata_ext = {24'h0, rd_byte_sh[7:0]};
            end
            SZ_H: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{wdata_in[15:0]}};
                rdata_ext = {16'h0, rd_half};
            end
            SZ_W: begin
                be        = 4'b1111;
                wdata     = wdata_in;
                rdata_ext = rdata;
            end
            default: begin
                be        = 4'b0000;
                wdata     = 32'h0;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the MEM stage. Runs one multi-cycle access
// on a synchronous single-port SRAM per request and stalls the pipeline
// until the access reaches DONE.
// Optional: define DMEM_ALIGN_CHK_EN to abort misaligned halfword/word
// accesses instead of aligning them down.
// Handshake: MEM holds REQ and its operands stable while STALL is high; the
// transfer completes in the DONE cycle (STALL low, DIN valid), REQ seen in
// DONE belongs to the finished request and is ignored.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ,
    input  logic              DRW,
    input  logic [31:0]       DADDR,
    input  logic [1:0]        DSIZE,
    input  logic [31:0]       DOUT,
    output logic [31:0]       DIN,
    output logic              STALL,
    output logic              ABORT,
    output logic              SRAM_CS,
    output logic              SRAM_WE,
    output logic [3:0]        SRAM_BE,
    output logic [ADDR_W-3:0] SRAM_ADDR,
    output logic [31:0]       SRAM_WDATA,
    input  logic [31:0]       SRAM_RDATA,
    output logic [1:0]        dbg_state
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t      state;
    logic        drw_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [3:0]  wcnt;

    logic [1:0]  lane_size;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        req_err;
    logic        last_cs;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^DADDR[31:ADDR_W];
    assign dbg_state      = state;

    // In IDLE the mapper works on the live request (to load the SRAM
    // outputs); afterwards it works on the latched size/offset for read data.
    assign lane_size = (state == ST_IDLE) ? DSIZE       : size_q;
    assign lane_off  = (state == ST_IDLE) ? DADDR[1:0]  : off_q;

`ifdef DMEM_ALIGN_CHK_EN
    assign req_err = (DSIZE == SZ_ERR) || is_misaligned(DSIZE, DADDR[1:0]);
`else
    assign req_err = (DSIZE == SZ_ERR);
`endif

    // Final cycle of the chip-select window, where SRAM_RDATA is valid.
    assign last_cs = ((state == ST_ACCESS) && (WAIT_CYCLES == 0)) ||
                     ((state == ST_WAIT) && (wcnt == 4'd1));

    // Freeze the pipeline while a request is being taken or the SRAM is busy;
    // forced low while reset is asserted.
    assign STALL = RESET_N & (((state == ST_IDLE) & REQ) |
                              (state == ST_ACCESS) | (state == ST_WAIT));

    dmem_lane u_lane (
        .size      (lane_size),
        .off       (lane_off),
        .wdata_in  (DOUT),
        .rdata     (SRAM_RDATA),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Access sequencer with registered SRAM-side and pipeline-side outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            drw_q      <= 1'b0;
            size_q     <= SZ_ERR;
            off_q      <= 2'b00;
            wcnt       <= 4'd0;
            DIN        <= 32'h0;
            ABORT      <= 1'b0;
            SRAM_CS    <= 1'b0;
            SRAM_WE    <= 1'b0;
            SRAM_BE    <= 4'b0000;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= 32'h0;
        end else begin
            ABORT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        drw_q  <= DRW;
                        size_q <= DSIZE;
                        off_q  <= DADDR[1:0];
                        if (req_err) begin
                            // Faulted request: no SRAM cycle, straight to DONE.
                            state <= ST_DONE;
                            ABORT <= 1'b1;
                            if ((DSIZE == SZ_ERR) && (DRW == DRW_READ)) begin
                                DIN <= 32'h0;
                            end
                        end else begin
                            state      <= ST_ACCESS;
                            SRAM_CS    <= 1'b1;
                            SRAM_WE    <= (DRW != DRW_READ);
                            SRAM_BE    <= lane_be;
                            SRAM_ADDR  <= DADDR[ADDR_W-1:2];
                            SRAM_WDATA <= lane_wdata;
                        end
                    end
                end
                ST_ACCESS, ST_WAIT: begin
                    if (last_cs) begin
                        state   <= ST_DONE;
                        SRAM_CS <= 1'b0;
                        SRAM_WE <= 1'b0;
                        if (drw_q == DRW_READ) begin
                            DIN <= lane_rdata;
                        end
                    end else if (state == ST_ACCESS) begin
                        wcnt  <= WAIT_LD;
                        state <= ST_WAIT;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Table-driven bench for dmem_ctrl with a behavioural SRAM model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int WC = 1;
    localparam logic WR = 1'b0;

    typedef struct {
        logic        drw;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] dout;
        logic        err;
        logic [3:0]  be;
        logic [13:0] saddr;
        logic [31:0] wdata;
        logic [31:0] din;
    } vec_t;

    logic        CLK;
    logic        RESET_N;
    logic        REQ;
    logic        DRW;
    logic [31:0] DADDR;
    logic [1:0]  DSIZE;
    logic [31:0] DOUT;
    logic [31:0] DIN;
    logic        STALL;
    logic        ABORT;
    logic        SRAM_CS;
    logic        SRAM_WE;
    logic [3:0]  SRAM_BE;
    logic [13:0] SRAM_ADDR;
    logic [31:0] SRAM_WDATA;
    logic [31:0] SRAM_RDATA;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    vec_t vecs [23];
    logic [31:0] mem [0:16383];

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    dmem_ctrl #(.ADDR_W(16), .WAIT_CYCLES(WC)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ        (REQ),
        .DRW        (DRW),
        .DADDR      (DADDR),
        .DSIZE      (DSIZE),
        .DOUT       (DOUT),
        .DIN        (DIN),
        .STALL      (STALL),
        .ABORT      (ABORT),
        .SRAM_CS    (SRAM_CS),
        .SRAM_WE    (SRAM_WE),
        .SRAM_BE    (SRAM_BE),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WDATA (SRAM_WDATA),
        .SRAM_RDATA (SRAM_RDATA),
        .dbg_state  (dbg_state)
    );

    // SRAM model: read data presented while selected, byte-enabled writes
    always_comb SRAM_RDATA = SRAM_CS ? mem[SRAM_ADDR] : 32'h0;

    always @(posedge CLK) begin
        if (SRAM_CS && SRAM_WE) begin
            for (int b = 0; b < 4; b++) begin
                if (SRAM_BE[b]) mem[SRAM_ADDR][8*b +: 8] <= SRAM_WDATA[8*b +: 8];
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one request, hold it until DONE, then check everything observed.
    task automatic run_vec(input int idx, input vec_t v);
        int stall_cnt = 0;
        int cs_cnt = 0;
        int abort_cnt = 0;
        int cyc = 0;
        logic done = 1'b0;
        logic unstable = 1'b0;
        logic [3:0]  be_c = 4'h0;
        logic [13:0] ad_c = 14'h0;
        logic [31:0] wd_c = 32'h0;
        logic        we_c = 1'b0;
        @(negedge CLK);
        REQ = 1'b1; DRW = v.drw; DADDR = v.addr; DSIZE = v.size; DOUT = v.dout;
        #1;
        while (!done && cyc < 40) begin
            if (STALL) stall_cnt++;
            if (ABORT) abort_cnt++;
            if (SRAM_CS) begin
                if (cs_cnt == 0) begin
                    be_c = SRAM_BE; ad_c = SRAM_ADDR; wd_c = SRAM_WDATA; we_c = SRAM_WE;
                end else if (be_c !== SRAM_BE || ad_c !== SRAM_ADDR ||
                             wd_c !== SRAM_WDATA || we_c !== SRAM_WE) begin
                    unstable = 1'b1;
                end
                cs_cnt++;
            end
            if (!STALL && cyc > 0) begin
                done = 1'b1;
                check32($sformatf("v%0d_din", idx), DIN, v.din);
                check32($sformatf("v%0d_done_abort", idx), {31'h0, ABORT}, {31'h0, v.err});
            end else begin
                @(negedge CLK);
                #1;
                cyc++;
            end
        end
        check32($sformatf("v%0d_completed", idx), {31'h0, done}, 32'h1);
        check32($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.err ? 32'd1 : 32'(WC + 2));
        check32($sformatf("v%0d_cs_cycles", idx), cs_cnt, v.err ? 32'd0 : 32'(WC + 1));
        check32($sformatf("v%0d_abort_cycles", idx), abort_cnt, {31'h0, v.err});
        if (!v.err) begin
            check32($sformatf("v%0d_be", idx), {28'h0, be_c}, {28'h0, v.be});
            check32($sformatf("v%0d_saddr", idx), {18'h0, ad_c}, {18'h0, v.saddr});
            check32($sformatf("v%0d_wdata", idx), wd_c, v.wdata);
            check32($sformatf("v%0d_we", idx), {31'h0, we_c}, {31'h0, ~v.drw});
            check32($sformatf("v%0d_stable", idx), {31'h0, unstable}, 32'h0);
        end
        // REQ was still high in DONE; it must not have started a new access.
        @(negedge CLK);
        REQ = 1'b0; DRW = 1'b0; DADDR = 32'h0; DSIZE = SZ_ERR; DOUT = 32'h0;
        #1;
        check32($sformatf("v%0d_idle_stall", idx), {31'h0, STALL}, 32'h0);
        check32($sformatf("v%0d_idle_cs", idx), {31'h0, SRAM_CS}, 32'h0);
        check32($sformatf("v%0d_idle_state", idx), {30'h0, dbg_state}, {30'h0, ST_IDLE});
    endtask

    initial begin
        vec_t v;
        // drw, addr, size, dout, err, be, saddr, wdata, din
        vecs[0]  = '{WR,       32'h0000_0010, SZ_W,   32'hDEADBEEF, 1'b0, 4'hF, 14'h004, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{DRW_READ, 32'h0000_0010, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{WR,       32'h0000_0013, SZ_B,   32'h0000_00A5, 1'b0, 4'h8, 14'h004, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[3]  = '{DRW_READ, 32'h0000_0010, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'hA5ADBEEF};
        vecs[4]  = '{DRW_READ, 32'h0000_0013, SZ_B,   32'h0,        1'b0, 4'h8, 14'h004, 32'h0,        32'h0000_00A5};
        vecs[5]  = '{WR,       32'h0000_0010, SZ_W,   32'h1234ABCD, 1'b0, 4'hF, 14'h004, 32'h1234ABCD, 32'h0000_00A5};
        vecs[6]  = '{DRW_READ, 32'h0000_0012, SZ_H,   32'h0,        1'b0, 4'hC, 14'h004, 32'h0,        32'h0000_1234};
        vecs[7]  = '{DRW_READ, 32'h0000_0010, SZ_H,   32'h0,        1'b0, 4'h3, 14'h004, 32'h0,        32'h0000_ABCD};
        vecs[8]  = '{WR,       32'h0000_0012, SZ_H,   32'h0000_5678, 1'b0, 4'hC, 14'h004, 32'h56785678, 32'h0000_ABCD};
        vecs[9]  = '{DRW_READ, 32'h0000_0010, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'h5678ABCD};
        vecs[10] = '{DRW_READ, 32'h0000_0011, SZ_B,   32'h0,        1'b0, 4'h2, 14'h004, 32'h0,        32'h0000_00AB};
        vecs[11] = '{WR,       32'h0000_0010, SZ_B,   32'h0000_0011, 1'b0, 4'h1, 14'h004, 32'h11111111, 32'h0000_00AB};
        vecs[12] = '{DRW_READ, 32'h0000_0012, SZ_B,   32'h0,        1'b0, 4'h4, 14'h004, 32'h0,        32'h0000_0078};
        vecs[13] = '{WR,       32'h0000_0014, SZ_W,   32'hCAFEF00D, 1'b0, 4'hF, 14'h005, 32'hCAFEF00D, 32'h0000_0078};
        vecs[14] = '{DRW_READ, 32'h0000_0016, SZ_H,   32'h0,        1'b0, 4'hC, 14'h005, 32'h0,        32'h0000_CAFE};
        vecs[15] = '{DRW_READ, 32'hFFFF_0014, SZ_W,   32'h0,        1'b0, 4'hF, 14'h005, 32'h0,        32'hCAFEF00D};
        vecs[16] = '{DRW_READ, 32'h0000_0010, SZ_ERR, 32'h0,        1'b1, 4'h0, 14'h000, 32'h0,        32'h0};
        vecs[17] = '{WR,       32'h0000_0010, SZ_ERR, 32'hFFFFFFFF, 1'b1, 4'h0, 14'h000, 32'h0,        32'h0};
        vecs[18] = '{DRW_READ, 32'h0000_0010, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'h5678AB11};
`ifdef DMEM_ALIGN_CHK_EN
        vecs[19] = '{DRW_READ, 32'h0000_0011, SZ_W,   32'h0,        1'b1, 4'h0, 14'h000, 32'h0,        32'h5678AB11};
        vecs[20] = '{DRW_READ, 32'h0000_0013, SZ_H,   32'h0,        1'b1, 4'h0, 14'h000, 32'h0,        32'h5678AB11};
        vecs[21] = '{WR,       32'h0000_0012, SZ_W,   32'h0,        1'b1, 4'h0, 14'h000, 32'h0,        32'h5678AB11};
        vecs[22] = '{DRW_READ, 32'h0000_0010, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'h5678AB11};
`else
        vecs[19] = '{DRW_READ, 32'h0000_0011, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'h5678AB11};
        vecs[20] = '{DRW_READ, 32'h0000_0013, SZ_H,   32'h0,        1'b0, 4'hC, 14'h004, 32'h0,        32'h0000_5678};
        vecs[21] = '{WR,       32'h0000_0012, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'h0000_5678};
        vecs[22] = '{DRW_READ, 32'h0000_0010, SZ_W,   32'h0,        1'b0, 4'hF, 14'h004, 32'h0,        32'h0};
`endif

        // reset state
        RESET_N = 1'b0; REQ = 1'b0; DRW = 1'b0; DADDR = 32'h0; DSIZE = SZ_ERR; DOUT = 32'h0;
        #1;
        check32("rst_din", DIN, 32'h0);
        check32("rst_stall", {31'h0, STALL}, 32'h0);
        check32("rst_abort", {31'h0, ABORT}, 32'h0);
        check32("rst_cs", {31'h0, SRAM_CS}, 32'h0);
        check32("rst_we", {31'h0, SRAM_WE}, 32'h0);
        check32("rst_be", {28'h0, SRAM_BE}, 32'h0);
        check32("rst_saddr", {18'h0, SRAM_ADDR}, 32'h0);
        check32("rst_wdata", SRAM_WDATA, 32'h0);
        check32("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 23; i++) run_vec(i, vecs[i]);

        // reset during WAIT: load something non-zero first so DIN clearing shows
        v = '{DRW_READ, 32'h0000_0014, SZ_W, 32'h0, 1'b0, 4'hF, 14'h005, 32'h0, 32'hCAFEF00D};
        run_vec(23, v);
        @(negedge CLK);
        REQ = 1'b1; DRW = DRW_READ; DADDR = 32'h0000_0014; DSIZE = SZ_W; DOUT = 32'h0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        check32("mid_state_wait", {30'h0, dbg_state}, {30'h0, ST_WAIT});
        check32("mid_cs_before", {31'h0, SRAM_CS}, 32'h1);
        check32("mid_stall_before", {31'h0, STALL}, 32'h1);
        RESET_N = 1'b0;
        #1;
        check32("mid_cs_after", {31'h0, SRAM_CS}, 32'h0);
        check32("mid_stall_after", {31'h0, STALL}, 32'h0);
        check32("mid_din_after", DIN, 32'h0);
        check32("mid_state_after", {30'h0, dbg_state}, {30'h0, ST_IDLE});
        @(negedge CLK);
        REQ = 1'b0; DSIZE = SZ_ERR; DADDR = 32'h0;
        @(negedge CLK);
        RESET_N = 1'b1;

        // fresh request after reset release
        v = '{DRW_READ, 32'h0000_0017, SZ_B, 32'h0, 1'b0, 4'h8, 14'h005, 32'h0, 32'h0000_00CA};
        run_vec(24, v);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
